hdlc_rx_frame_ctrl: RTL and testbench

//  Frame-level sequencer for the HDLC receive path, between the bit-level decoder and the Rx buffer/register block.

---
 rtl/hdlc_rx_frame_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_hdlc_rx_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// hdlc_rx_frame_ctrl
// Frame-level sequencer for the HDLC receive path. It sits between the
// bit-level decoder (flag / abort / byte events) and the Rx buffer and
// register block. It frames incoming bytes, strobes them into the buffer,
// checks frame length and FCS result, and raises the Rx status bits.
//
// Ports
//   Clk, Rst        : system clock, synchronous active-high reset
//   Rx_Enable       : receiver enable from the control register
//   Rx_FlagDetect   : 1-cycle pulse, flag decoded
//   Rx_AbortDetect  : 1-cycle pulse, abort decoded
//   Rx_NewByte      : 1-cycle pulse, de-stuffed byte valid on Rx_Data
//   Rx_Data         : decoded byte
//   Rx_FCSen        : last two bytes of a frame are FCS
//   Rx_FCSErr       : FCS checker result, sampled with the closing flag
//   Rx_Drop         : host discards the current / held frame
//   Rx_ReadDone     : host finished reading the held frame
//   Rx_ValidFrame   : high while a frame is being received
//   Rx_WrBuff       : buffer write strobe, Rx_DataBuff is the byte
//   Rx_EoF          : 1-cycle pulse when a frame ends (flag or abort)
//   Rx_FrameSize    : payload byte count of the last frame
//   Rx_Ready        : good frame waiting in the buffer
//   Rx_Overflow     : frame exceeded MAX_BYTES
//   Rx_AbortSignal  : frame was aborted
//   Rx_FrameError   : FCS error or frame shorter than MIN_BYTES
// ---------------------------------------------------------------------------
module hdlc_rx_frame_ctrl #(
    parameter int MAX_BYTES = 128,
    parameter int MIN_BYTES = 4,
    parameter int SIZE_W    = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Rx_Enable,
    input  logic              Rx_FlagDetect,
    input  logic              Rx_AbortDetect,
    input  logic              Rx_NewByte,
    input  logic [7:0]        Rx_Data,
    input  logic              Rx_FCSen,
    input  logic              Rx_FCSErr,
    input  logic              Rx_Drop,
    input  logic              Rx_ReadDone,
    output logic              Rx_ValidFrame,
    output logic              Rx_WrBuff,
    output logic [7:0]        Rx_DataBuff,
    output logic              Rx_EoF,
    output logic [SIZE_W-1:0] Rx_FrameSize,
    output logic              Rx_Ready,
    output logic              Rx_Overflow,
    output logic              Rx_AbortSignal,
    output logic              Rx_FrameError
);

    typedef enum logic [1:0] {IDLE, SYNC, FRAME, HOLD} state_t;

    state_t            r_state, w_state;
    logic [SIZE_W-1:0] r_count, w_count;
    logic              r_validFrame, w_validFrame;
    logic              r_wrBuff, w_wrBuff;
    logic [7:0]        r_dataBuff, w_dataBuff;
    logic              r_eof, w_eof;
    logic [SIZE_W-1:0] r_frameSize, w_frameSize;
    logic              r_ready, w_ready;
    logic              r_overflow, w_overflow;
    logic              r_abortSignal, w_abortSignal;
    logic              r_frameError, w_frameError;

    // Close-of-frame checks: the length test uses the raw byte count
    // (FCS included); the reported size strips the FCS, never below zero.
    logic              w_closeErr;
    logic [SIZE_W-1:0] w_closeSize;

    assign w_closeErr  = (Rx_FCSen & Rx_FCSErr) | (r_count < SIZE_W'(MIN_BYTES));
    assign w_closeSize = !Rx_FCSen                 ? r_count :
                         (r_count >= SIZE_W'(2))   ? r_count - SIZE_W'(2) :
                                                     '0;

    // State and every output are registered together, so each decoder or
    // host event shows up on the outputs exactly one cycle later.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_validFrame  <= 1'b0;
            r_wrBuff      <= 1'b0;
            r_dataBuff    <= '0;
            r_eof         <= 1'b0;
            r_frameSize   <= '0;
            r_ready       <= 1'b0;
            r_overflow    <= 1'b0;
            r_abortSignal <= 1'b0;
            r_frameError  <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_count       <= w_count;
            r_validFrame  <= w_validFrame;
            r_wrBuff      <= w_wrBuff;
            r_dataBuff    <= w_dataBuff;
            r_eof         <= w_eof;
            r_frameSize   <= w_frameSize;
            r_ready       <= w_ready;
            r_overflow    <= w_overflow;
            r_abortSignal <= w_abortSignal;
            r_frameError  <= w_frameError;
        end
    end

    // Next-state and next-output logic. Status bits hold by default; the
    // write strobe and EoF are pulses and default low. Host actions (Drop,
    // disable) are handled ahead of decoder events, and among decoder
    // events abort beats flag beats byte, so a losing byte is never written.
    always_comb begin
        w_state       = r_state;
        w_count       = r_count;
        w_validFrame  = r_validFrame;
        w_wrBuff      = 1'b0;
        w_dataBuff    = r_dataBuff;
        w_eof         = 1'b0;
        w_frameSize   = r_frameSize;
        w_ready       = r_ready;
        w_overflow    = r_overflow;
        w_abortSignal = r_abortSignal;
        w_frameError  = r_frameError;

        case (r_state)
            IDLE: begin
                if (Rx_FlagDetect && Rx_Enable) begin
                    w_state = SYNC;
                end
            end

            SYNC, FRAME: begin
                if (Rx_Drop) begin
                    w_state       = IDLE;
                    w_validFrame  = 1'b0;
                    w_ready       = 1'b0;
                    w_overflow    = 1'b0;
                    w_abortSignal = 1'b0;
                    w_frameError  = 1'b0;
                end else if (!Rx_Enable) begin
                    w_state      = IDLE;
                    w_validFrame = 1'b0;
                end else if (Rx_AbortDetect) begin
                    w_state = IDLE;
                    if (r_state == FRAME) begin
                        w_abortSignal = 1'b1;
                        w_eof         = 1'b1;
                        w_validFrame  = 1'b0;
                        w_ready       = 1'b0;
                        w_frameSize   = '0;
                    end
                end else if (Rx_FlagDetect) begin
                    // In FRAME this is the closing flag; a bad frame reuses
                    // it as the opening flag of the next one.
                    if (r_state == FRAME) begin
                        w_eof        = 1'b1;
                        w_validFrame = 1'b0;
                        w_frameSize  = w_closeSize;
                        w_frameError = w_closeErr;
                        w_ready      = !w_closeErr;
                        w_state      = w_closeErr ? SYNC : HOLD;
                    end
                end else if (Rx_NewByte) begin
                    if (r_state == SYNC) begin
                        w_state       = FRAME;
                        w_validFrame  = 1'b1;
                        w_wrBuff      = 1'b1;
                        w_dataBuff    = Rx_Data;
                        w_count       = SIZE_W'(1);
                        w_overflow    = 1'b0;
                        w_abortSignal = 1'b0;
                        w_frameError  = 1'b0;
                    end else if (r_count < SIZE_W'(MAX_BYTES)) begin
                        w_wrBuff   = 1'b1;
                        w_dataBuff = Rx_Data;
                        w_count    = r_count + SIZE_W'(1);
                    end else begin
                        w_overflow = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (Rx_ReadDone || Rx_Drop) begin
                    w_state     = IDLE;
                    w_ready     = 1'b0;
                    w_overflow  = 1'b0;
                    w_frameSize = '0;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign Rx_ValidFrame  = r_validFrame;
    assign Rx_WrBuff      = r_wrBuff;
    assign Rx_DataBuff    = r_dataBuff;
    assign Rx_EoF         = r_eof;
    assign Rx_FrameSize   = r_frameSize;
    assign Rx_Ready       = r_ready;
    assign Rx_Overflow    = r_overflow;
    assign Rx_AbortSignal = r_abortSignal;
    assign Rx_FrameError  = r_frameError;

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hdlc_rx_frame_ctrl
// Directed bench for hdlc_rx_frame_ctrl: drives decoder and host events one
// cycle at a time and compares the registered outputs against hand-computed
// values. A negedge monitor logs every buffer write and watches the
// output invariants.
// ---------------------------------------------------------------------------
module tb_hdlc_rx_frame_ctrl;

    localparam int EV_IDLE  = 0;
    localparam int EV_FLAG  = 1;
    localparam int EV_ABORT = 2;
    localparam int EV_BYTE  = 3;
    localparam int EV_DROP  = 4;
    localparam int EV_READ  = 5;
    localparam int EV_RESET = 6;

    logic       Clk;
    logic       Rst;
    logic       Rx_Enable;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_NewByte;
    logic [7:0] Rx_Data;
    logic       Rx_FCSen;
    logic       Rx_FCSErr;
    logic       Rx_Drop;
    logic       Rx_ReadDone;
    logic       Rx_ValidFrame;
    logic       Rx_WrBuff;
    logic [7:0] Rx_DataBuff;
    logic       Rx_EoF;
    logic [7:0] Rx_FrameSize;
    logic       Rx_Ready;
    logic       Rx_Overflow;
    logic       Rx_AbortSignal;
    logic       Rx_FrameError;

    int total = 0;
    int bad   = 0;

    logic [7:0] wrLog [0:511];
    int         wrCount = 0;
    int         wrBase  = 0;
    logic       prevEof = 1'b0;

    logic [22:0] allOut;
    assign allOut = {Rx_ValidFrame, Rx_WrBuff, Rx_DataBuff, Rx_EoF, Rx_FrameSize,
                     Rx_Ready, Rx_Overflow, Rx_AbortSignal, Rx_FrameError};

    hdlc_rx_frame_ctrl #(
        .MAX_BYTES (128),
        .MIN_BYTES (4),
        .SIZE_W    (8)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Rx_Enable      (Rx_Enable),
        .Rx_FlagDetect  (Rx_FlagDetect),
        .Rx_AbortDetect (Rx_AbortDetect),
        .Rx_NewByte     (Rx_NewByte),
        .Rx_Data        (Rx_Data),
        .Rx_FCSen       (Rx_FCSen),
        .Rx_FCSErr      (Rx_FCSErr),
        .Rx_Drop        (Rx_Drop),
        .Rx_ReadDone    (Rx_ReadDone),
        .Rx_ValidFrame  (Rx_ValidFrame),
        .Rx_WrBuff      (Rx_WrBuff),
        .Rx_DataBuff    (Rx_DataBuff),
        .Rx_EoF         (Rx_EoF),
        .Rx_FrameSize   (Rx_FrameSize),
        .Rx_Ready       (Rx_Ready),
        .Rx_Overflow    (Rx_Overflow),
        .Rx_AbortSignal (Rx_AbortSignal),
        .Rx_FrameError  (Rx_FrameError)
    );

    // 100 MHz-style free-running clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Presents one event for exactly one clock edge, then returns 1 ns after
    // that edge so the caller sees the registered response.
    task automatic applyStimulus(input int kind, input logic [7:0] d);
        case (kind)
            EV_FLAG:  Rx_FlagDetect  = 1'b1;
            EV_ABORT: Rx_AbortDetect = 1'b1;
            EV_BYTE:  begin Rx_NewByte = 1'b1; Rx_Data = d; end
            EV_DROP:  Rx_Drop        = 1'b1;
            EV_READ:  Rx_ReadDone    = 1'b1;
            EV_RESET: Rst            = 1'b1;
            default:  ;
        endcase
        @(posedge Clk);
        #1;
        Rx_FlagDetect  = 1'b0;
        Rx_AbortDetect = 1'b0;
        Rx_NewByte     = 1'b0;
        Rx_Drop        = 1'b0;
        Rx_ReadDone    = 1'b0;
        Rst            = 1'b0;
    endtask

    // Logs every buffer write and checks the output invariants mid-cycle.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (Rx_WrBuff) begin
                wrLog[wrCount % 512] = Rx_DataBuff;
                wrCount++;
                checkOutput("wrNeedsValid", {31'd0, Rx_ValidFrame}, 32'd1);
            end
            if (Rx_EoF) checkOutput("eofTwice", {31'd0, prevEof}, 32'd0);
            if (Rx_Ready || Rx_AbortSignal)
                checkOutput("readyAndAbort", {31'd0, Rx_Ready & Rx_AbortSignal}, 32'd0);
        end
        prevEof = Rx_EoF;
    end

    initial begin
        Rst = 1'b1; Rx_Enable = 1'b0; Rx_FlagDetect = 1'b0; Rx_AbortDetect = 1'b0;
        Rx_NewByte = 1'b0; Rx_Data = 8'h00; Rx_FCSen = 1'b0; Rx_FCSErr = 1'b0;
        Rx_Drop = 1'b0; Rx_ReadDone = 1'b0;

        // Reset state
        applyStimulus(EV_RESET, 8'h00);
        checkOutput("resetOuts", {9'd0, allOut}, 32'd0);
        Rx_Enable = 1'b1;
        Rx_FCSen  = 1'b1;

        // T1: good 6-byte frame with FCS
        wrBase = wrCount;
        applyStimulus(EV_FLAG, 8'h00);
        applyStimulus(EV_BYTE, 8'h11);
        checkOutput("t1Valid", {31'd0, Rx_ValidFrame}, 32'd1);
        checkOutput("t1Wr", {31'd0, Rx_WrBuff}, 32'd1);
        checkOutput("t1Data", {24'd0, Rx_DataBuff}, 32'h11);
        for (int i = 1; i < 6; i++) applyStimulus(EV_BYTE, 8'h11 + 8'(i));
        applyStimulus(EV_FLAG, 8'h00);
        checkOutput("t1Eof", {31'd0, Rx_EoF}, 32'd1);
        checkOutput("t1ValidLow", {31'd0, Rx_ValidFrame}, 32'd0);
        checkOutput("t1Size", {24'd0, Rx_FrameSize}, 32'd4);
        checkOutput("t1Ready", {31'd0, Rx_Ready}, 32'd1);
        checkOutput("t1FrameErr", {31'd0, Rx_FrameError}, 32'd0);
        checkOutput("t1WrCount", wrCount - wrBase, 32'd6);
        for (int i = 0; i < 6; i++)
            checkOutput("t1WrData", {24'd0, wrLog[(wrBase + i) % 512]}, 32'h11 + i);
        applyStimulus(EV_IDLE, 8'h00);
        checkOutput("t1EofPulse", {31'd0, Rx_EoF}, 32'd0);
        checkOutput("t1ReadyHeld", {31'd0, Rx_Ready}, 32'd1);
        applyStimulus(EV_READ, 8'h00);
        checkOutput("t1ReadDone", {31'd0, Rx_Ready}, 32'd0);
        checkOutput("t1SizeClr", {24'd0, Rx_FrameSize}, 32'd0);

        // T2: FCS error, then a frame reusing the closing flag
        applyStimulus(EV_FLAG, 8'h00);
        for (int i = 0; i < 6; i++) applyStimulus(EV_BYTE, 8'h21 + 8'(i));
        Rx_FCSErr = 1'b1;
        applyStimulus(EV_FLAG, 8'h00);
        Rx_FCSErr = 1'b0;
        checkOutput("t2FrameErr", {31'd0, Rx_FrameError}, 32'd1);
        checkOutput("t2Ready", {31'd0, Rx_Ready}, 32'd0);
        checkOutput("t2Eof", {31'd0, Rx_EoF}, 32'd1);
        wrBase = wrCount;
        applyStimulus(EV_BYTE, 8'h31);
        checkOutput("t2Reopen", {31'd0, Rx_ValidFrame}, 32'd1);
        checkOutput("t2ErrClr", {31'd0, Rx_FrameError}, 32'd0);
        for (int i = 1; i < 6; i++) applyStimulus(EV_BYTE, 8'h31 + 8'(i));
        applyStimulus(EV_FLAG, 8'h00);
        checkOutput("t2Ready2", {31'd0, Rx_Ready}, 32'd1);
        checkOutput("t2Size2", {24'd0, Rx_FrameSize}, 32'd4);
        checkOutput("t2WrCount", wrCount - wrBase, 32'd6);
        applyStimulus(EV_READ, 8'h00);

        // T3: abort after 3 bytes
        wrBase = wrCount;
        applyStimulus(EV_FLAG, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(EV_BYTE, 8'h41 + 8'(i));
        applyStimulus(EV_ABORT, 8'h00);
        checkOutput("t3Abort", {31'd0, Rx_AbortSignal}, 32'd1);
        checkOutput("t3Eof", {31'd0, Rx_EoF}, 32'd1);
        checkOutput("t3Valid", {31'd0, Rx_ValidFrame}, 32'd0);
        checkOutput("t3Ready", {31'd0, Rx_Ready}, 32'd0);
        checkOutput("t3Size", {24'd0, Rx_FrameSize}, 32'd0);
        applyStimulus(EV_IDLE, 8'h00);
        checkOutput("t3WrCount", wrCount - wrBase, 32'd3);

        // T4: 130-byte frame overflows the 128-byte buffer
        wrBase = wrCount;
        applyStimulus(EV_FLAG, 8'h00);
        applyStimulus(EV_BYTE, 8'd1);
        checkOutput("t4AbortClr", {31'd0, Rx_AbortSignal}, 32'd0);
        for (int i = 2; i <= 128; i++) applyStimulus(EV_BYTE, 8'(i));
        checkOutput("t4NoOvfYet", {31'd0, Rx_Overflow}, 32'd0);
        applyStimulus(EV_BYTE, 8'd129);
        checkOutput("t4Ovf", {31'd0, Rx_Overflow}, 32'd1);
        checkOutput("t4NoWr", {31'd0, Rx_WrBuff}, 32'd0);
        applyStimulus(EV_BYTE, 8'd130);
        applyStimulus(EV_FLAG, 8'h00);
        checkOutput("t4Size", {24'd0, Rx_FrameSize}, 32'd126);
        checkOutput("t4Ready", {31'd0, Rx_Ready}, 32'd1);
        checkOutput("t4OvfSticky", {31'd0, Rx_Overflow}, 32'd1);
        checkOutput("t4WrCount", wrCount - wrBase, 32'd128);
        checkOutput("t4LastWr", {24'd0, wrLog[(wrCount - 1) % 512]}, 32'd128);

        // T5: decoder events ignored while holding a frame
        wrBase = wrCount;
        applyStimulus(EV_FLAG, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(EV_BYTE, 8'h51 + 8'(i));
        applyStimulus(EV_IDLE, 8'h00);
        checkOutput("t5NoWr", wrCount - wrBase, 32'd0);
        checkOutput("t5ReadyHeld", {31'd0, Rx_Ready}, 32'd1);
        applyStimulus(EV_READ, 8'h00);
        checkOutput("t5Ready", {31'd0, Rx_Ready}, 32'd0);
        checkOutput("t5Ovf", {31'd0, Rx_Overflow}, 32'd0);
        checkOutput("t5Size", {24'd0, Rx_FrameSize}, 32'd0);
        applyStimulus(EV_BYTE, 8'h77);
        applyStimulus(EV_IDLE, 8'h00);
        checkOutput("t5IdleNoWr", wrCount - wrBase, 32'd0);

        // Receiver disabled mid-frame, then host drop mid-frame
        applyStimulus(EV_FLAG, 8'h00);
        applyStimulus(EV_BYTE, 8'h61);
        Rx_Enable = 1'b0;
        applyStimulus(EV_IDLE, 8'h00);
        Rx_Enable = 1'b1;
        checkOutput("disValid", {31'd0, Rx_ValidFrame}, 32'd0);
        checkOutput("disEof", {31'd0, Rx_EoF}, 32'd0);
        applyStimulus(EV_FLAG, 8'h00);
        applyStimulus(EV_BYTE, 8'h62);
        applyStimulus(EV_DROP, 8'h00);
        checkOutput("dropValid", {31'd0, Rx_ValidFrame}, 32'd0);
        checkOutput("dropEof", {31'd0, Rx_EoF}, 32'd0);

        // T6: short frame, then reset in the middle of the next frame
        applyStimulus(EV_FLAG, 8'h00);
        applyStimulus(EV_BYTE, 8'h71);
        applyStimulus(EV_BYTE, 8'h72);
        applyStimulus(EV_FLAG, 8'h00);
        checkOutput("t6FrameErr", {31'd0, Rx_FrameError}, 32'd1);
        checkOutput("t6Ready", {31'd0, Rx_Ready}, 32'd0);
        checkOutput("t6Size", {24'd0, Rx_FrameSize}, 32'd0);
        applyStimulus(EV_BYTE, 8'h73);
        checkOutput("t6Valid", {31'd0, Rx_ValidFrame}, 32'd1);
        applyStimulus(EV_BYTE, 8'h74);
        applyStimulus(EV_RESET, 8'h00);
        checkOutput("t6ResetOuts", {9'd0, allOut}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
